// File: rtl/ms_pkg.sv
// Shared board geometry, FSM state encoding and index helpers for the
// mine neighbour counter.
//   ROWS, COLS  board dimensions
//   CELLS       ROWS*COLS, one bit per cell in the mine map
//   IDX_W       cell index width (2**IDX_W >= CELLS)
//   state_t     scan controller states
//   idx_row/col split a linear cell index (row*COLS + col)
package ms_pkg;

  localparam int ROWS  = 8;
  localparam int COLS  = 8;
  localparam int CELLS = ROWS * COLS;
  localparam int IDX_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int idx_row(input logic [IDX_W-1:0] idx);
    return int'(idx) / COLS;
  endfunction

  function automatic int idx_col(input logic [IDX_W-1:0] idx);
    return int'(idx) % COLS;
  endfunction

endpackage

// File: rtl/cell_neighbors.sv
// Combinational adjacency evaluator for one cell of the board.
// Ports:
//   map       in   latched mine map, bit i = mine at cell i
//   idx       in   cell being evaluated
//   nbr_mask  out  bit k set when neighbour k lies on the board
//                  (k order: NW, N, NE, W, E, SW, S, SE)
//   count     out  number of on-board neighbours holding a mine (0..8)
//   self_mine out  the evaluated cell itself holds a mine
module cell_neighbors
  import ms_pkg::*;
(
  input  logic [CELLS-1:0] map,
  input  logic [IDX_W-1:0] idx,
  output logic [7:0]       nbr_mask,
  output logic [3:0]       count,
  output logic             self_mine
);

  localparam int DR [8] = '{-1, -1, -1,  0, 0,  1, 1, 1};
  localparam int DC [8] = '{-1,  0,  1, -1, 1, -1, 0, 1};

  int row;
  int col;
  int nr;
  int nc;
  int nbr;

  assign self_mine = map[idx];

  // Edge clipping: out-of-board neighbours are masked off, never wrapped.
  always_comb begin
    nbr_mask = '0;
    count    = '0;
    row      = idx_row(idx);
    col      = idx_col(idx);
    nr       = 0;
    nc       = 0;
    nbr      = 0;
    for (int k = 0; k < 8; k++) begin
      nr = row + DR[k];
      nc = col + DC[k];
      if (nr >= 0 && nr < ROWS && nc >= 0 && nc < COLS) begin
        nbr_mask[3'(k)] = 1'b1;
        nbr             = nr * COLS + nc;
        if (map[IDX_W'(nbr)]) count = count + 4'd1;
      end
    end
  end

endmodule

// File: rtl/mine_neighbor_counter.sv
// Scans a latched mine map cell by cell, presenting each cell's adjacent-mine
// count over a valid/ready handshake and building a packed count map.
// Optional build macro: NEIGHBOR_COUNTER_TOTAL_EN adds mine_total, the
// popcount of the latched map.
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   start        begin a scan (only honoured in IDLE)
//   mine_map     bit i = mine at cell i
//   busy         high in SCAN and DONE
//   cell_valid / cell_ready   per-cell result handshake
//   cell_idx, cell_count, cell_mine   presented cell result
//   count_map    nibble i = adjacent-mine count of cell i
//   done         one-cycle pulse after the last cell is accepted
//   mine_total   (optional) number of mines in the latched map
//
// state | meaning
// IDLE  | waiting for start; outputs reflect last latched map
// SCAN  | presenting cell idx, advancing on each accepted result
// DONE  | one-cycle completion pulse, then back to IDLE
module mine_neighbor_counter
  import ms_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [CELLS-1:0]   mine_map,
  output logic               busy,
  output logic               cell_valid,
  input  logic               cell_ready,
  output logic [IDX_W-1:0]   cell_idx,
  output logic [3:0]         cell_count,
  output logic               cell_mine,
  output logic [4*CELLS-1:0] count_map,
  output logic               done
`ifdef NEIGHBOR_COUNTER_TOTAL_EN
  ,
  output logic [IDX_W:0]     mine_total
`endif
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CELLS - 1);

  state_t             state_q;
  state_t             state_d;
  logic [IDX_W-1:0]   idx_q;
  logic [CELLS-1:0]   map_q;
  logic               latch;
  logic               accept;
  // Neighbour mask is produced for the render path; not consumed in this block.
  logic [7:0]         nbr_mask_unused;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    busy       = 1'b0;
    cell_valid = 1'b0;
    done       = 1'b0;
    latch      = 1'b0;
    accept     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          latch   = 1'b1;
          state_d = SCAN;
        end
      end
      SCAN: begin
        busy       = 1'b1;
        cell_valid = 1'b1;
        if (cell_ready) begin
          accept = 1'b1;
          if (idx_q == LAST_IDX) state_d = DONE;
        end
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q <= '0;
      map_q <= '0;
    end else if (latch) begin
      idx_q <= '0;
      map_q <= mine_map;
    end else if (accept) begin
      idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
    end
  end

  cell_neighbors u_cell_neighbors (
    .map       (map_q),
    .idx       (idx_q),
    .nbr_mask  (nbr_mask_unused),
    .count     (cell_count),
    .self_mine (cell_mine)
  );

  assign cell_idx = idx_q;

  // One nibble register per cell, written when its index is accepted.
  for (genvar g = 0; g < CELLS; g++) begin : g_nib
    logic [3:0] nib_q;
    always_ff @(posedge clk or posedge reset) begin
      if (reset)                                 nib_q <= '0;
      else if (latch)                            nib_q <= '0;
      else if (accept && idx_q == IDX_W'(g))     nib_q <= cell_count;
    end
    assign count_map[g*4 +: 4] = nib_q;
  end

`ifdef NEIGHBOR_COUNTER_TOTAL_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      mine_total <= '0;
    else if (latch) mine_total <= (IDX_W+1)'($countones(mine_map));
  end
`endif

endmodule

// File: tb/tb_mine_neighbor_counter.sv
module tb_mine_neighbor_counter;

  logic         clk;
  logic         reset;
  logic         start;
  logic [63:0]  mine_map;
  logic         busy;
  logic         cell_valid;
  logic         cell_ready;
  logic [5:0]   cell_idx;
  logic [3:0]   cell_count;
  logic         cell_mine;
  logic [255:0] count_map;
  logic         done;
`ifdef NEIGHBOR_COUNTER_TOTAL_EN
  logic [6:0]   mine_total;
`endif

  int n_checks;
  int n_fail;
  logic [10:0] sb_q [$];

  mine_neighbor_counter dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .mine_map   (mine_map),
    .busy       (busy),
    .cell_valid (cell_valid),
    .cell_ready (cell_ready),
    .cell_idx   (cell_idx),
    .cell_count (cell_count),
    .cell_mine  (cell_mine),
    .count_map  (count_map),
    .done       (done)
`ifdef NEIGHBOR_COUNTER_TOTAL_EN
    ,
    .mine_total (mine_total)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] model_count(input logic [63:0] m, input int i);
    int r;
    int c;
    logic [3:0] n;
    r = i / 8;
    c = i % 8;
    n = 4'd0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        if (!(dr == 0 && dc == 0) && (r + dr) >= 0 && (r + dr) < 8 &&
            (c + dc) >= 0 && (c + dc) < 8)
          if (m[6'((r + dr) * 8 + c + dc)]) n = n + 4'd1;
    return n;
  endfunction

  // abort_at >= 0: assert reset when that cell is presented and stop there.
  task automatic run_scan(input logic [63:0] map, input int stall_at, input int stall_len,
                          input int exp_done, input bit pulse_start, input int abort_at);
    int cyc;
    int hs;
    int stalls;
    bit got_done;
    logic [10:0] held;
    logic [10:0] exp_cell;
    logic [255:0] exp_cm;

    exp_cm = '0;
    @(negedge clk);
    mine_map   = map;
    start      = 1'b1;
    cell_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      sb_q.push_back({6'(i), model_count(map, i), map[6'(i)]});
      exp_cm[i*4 +: 4] = model_count(map, i);
    end
    cyc = 0; hs = 0; stalls = 0; got_done = 1'b0; held = '0;

    while (!got_done && cyc < 200) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      start = pulse_start && (cyc == 30 || cyc == exp_done);
      if (pulse_start && cyc == 2) mine_map = ~map;

      if (abort_at >= 0 && cell_valid && int'(cell_idx) == abort_at) begin
        reset = 1'b1;
        #1;
        check("abort_busy", 256'(busy), 256'(0));
        check("abort_valid", 256'(cell_valid), 256'(0));
        check("abort_count_map", count_map, '0);
        check("abort_idx", 256'(cell_idx), 256'(0));
        sb_q.delete();
        @(negedge clk);
        reset = 1'b0;
        return;
      end

      if (cell_valid) begin
        if (stall_at >= 0 && int'(cell_idx) == stall_at && stalls < stall_len) begin
          if (stalls == 0) held = {cell_idx, cell_count, cell_mine};
          else check("stall_hold", 256'({cell_idx, cell_count, cell_mine}), 256'(held));
          cell_ready = 1'b0;
          stalls++;
        end else begin
          cell_ready = 1'b1;
        end
        if (cell_ready) begin
          if (sb_q.size() == 0) begin
            check("sb_empty", 256'(1), 256'(0));
          end else begin
            exp_cell = sb_q.pop_front();
            check("cell", 256'({cell_idx, cell_count, cell_mine}), 256'(exp_cell));
          end
          hs++;
        end
      end

      if (done) begin
        got_done = 1'b1;
        check("done_cycle", 256'(cyc), 256'(exp_done));
        check("busy_at_done", 256'(busy), 256'(1));
        check("handshakes", 256'(hs), 256'(64));
        check("count_map", count_map, exp_cm);
`ifdef NEIGHBOR_COUNTER_TOTAL_EN
        check("mine_total", 256'(mine_total), 256'($countones(map)));
`endif
      end
    end

    if (!got_done) check("done_timeout", 256'(0), 256'(1));
    @(negedge clk);
    start = 1'b0;
    check("busy_after_done", 256'(busy), 256'(0));
    check("done_one_cycle", 256'(done), 256'(0));
    @(negedge clk);
    check("idle_no_valid", 256'(cell_valid), 256'(0));
    check("idle_no_done", 256'(done), 256'(0));
    check("sb_drained", 256'(sb_q.size()), 256'(0));
    mine_map = map;
  endtask

  initial begin
    logic [63:0] rmap;
    n_checks   = 0;
    n_fail     = 0;
    reset      = 1'b1;
    start      = 1'b0;
    cell_ready = 1'b1;
    mine_map   = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", 256'(busy), 256'(0));
    check("rst_valid", 256'(cell_valid), 256'(0));
    check("rst_done", 256'(done), 256'(0));
    check("rst_idx", 256'(cell_idx), 256'(0));
    check("rst_count", 256'(cell_count), 256'(0));
    check("rst_mine", 256'(cell_mine), 256'(0));
    check("rst_count_map", count_map, '0);
`ifdef NEIGHBOR_COUNTER_TOTAL_EN
    check("rst_total", 256'(mine_total), 256'(0));
`endif
    reset = 1'b0;

    run_scan(64'h0, -1, 0, 65, 1'b0, -1);
    run_scan(64'h0000_0000_0000_0001, -1, 0, 65, 1'b0, -1);
    run_scan(64'hFFFF_FFFF_FFFF_FFFF, -1, 0, 65, 1'b0, -1);
    run_scan(64'h8000_0000_0000_0001, 10, 3, 68, 1'b0, -1);
    run_scan(64'hA5C3_0F96_5A3C_F069, -1, 0, 65, 1'b0, 20);
    run_scan(64'hA5C3_0F96_5A3C_F069, -1, 0, 65, 1'b0, -1);
    run_scan(64'h0123_4567_89AB_CDEF, -1, 0, 65, 1'b1, -1);
    for (int t = 0; t < 3; t++) begin
      rmap = {$urandom, $urandom};
      run_scan(rmap, int'($urandom_range(0, 63)), 2 + t, 67 + t, 1'b0, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
